// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard / sequencing controller for a 5-stage 32-bit MIPS pipeline.
// Each cycle it decides whether the PC and IF/ID advance, whether IF/ID is
// flushed, whether ID/EX loads a bubble, and whether EX is held by a
// multi-cycle mul/div. It handles:
//   * load-use stalls (one bubble cycle),
//   * taken-branch flushes resolved in EX,
//   * mul/div occupancy of EX for MULDIV_LAT cycles.
//
// Only the state and the 4-bit down-counter are registered. All control
// outputs are a zero-latency combinational decode of state, counter and
// the current inputs.
//
// Parameters:
//   MULDIV_LAT  total EX-stage cycles of a mul/div op (1..16)
//   CNT_W       width of the stall counter (optional feature only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, adds output stall_count, a saturating count of cycles
//   outside INIT in which pc_write is low. Cleared by reset_in.
//
// Ports:
//   clk              in   pipeline clock, rising edge
//   reset_in         in   asynchronous, active-low reset
//   ifid_rs          in   rs field of instruction in IF/ID
//   ifid_rt          in   rt field of instruction in IF/ID
//   ifid_uses_rt     in   IF/ID instruction reads rt as a source
//   idex_memread     in   instruction in ID/EX is a load
//   idex_rt          in   destination rt of instruction in ID/EX
//   ex_branch_taken  in   branch in EX resolved taken this cycle
//   ex_muldiv_start  in   first EX cycle of a mul/div op
//   pc_write         out  PC register load enable
//   ifid_write       out  IF/ID load enable
//   ifid_flush       out  IF/ID loads NOP
//   idex_bubble      out  ID/EX loads zero WB/M/EX control fields
//   ex_hold          out  ID/EX and EX hold; EX/MEM loads bubble
//   ctrl_state       out  current state encoding (debug)
//   stall_count      out  saturating stall counter (HAZARD_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  // Reject illegal parameter values at elaboration time.
  generate
    if (MULDIV_LAT < 1 || MULDIV_LAT > 16 || CNT_W < 1) begin : g_bad_params
      $error("pipeline_hazard_ctrl: MULDIV_LAT must be 1..16 and CNT_W >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_MULDIV = 2'd2
  } state_t;

  // A single-cycle mul/div never needs the MULDIV state.
  localparam logic       MD_MULTI    = (MULDIV_LAT > 1);
  // The start cycle is spent in RUN and the release cycle at cnt==0, so the
  // counter covers the remaining MULDIV_LAT-2 hold cycles.
  localparam logic [3:0] MD_CNT_INIT = (MULDIV_LAT > 1) ? 4'(MULDIV_LAT - 2) : 4'd0;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic is_run;
  logic is_muldiv;
  logic load_use;

  // Encoding 3 is unused and falls through to INIT behaviour.
  assign is_run    = (state_reg == ST_RUN);
  assign is_muldiv = (state_reg == ST_MULDIV);

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_comb begin
    // INIT values by default: front end frozen and flushed.
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    ex_hold     = 1'b0;
    ctrl_state  = 2'd0;
    state_next  = ST_RUN;
    cnt_next    = 4'd0;

    if (is_run) begin
      ctrl_state  = 2'd1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (ex_branch_taken) begin
        // Wrong-path instructions in IF/ID and ID are squashed; the
        // redirected PC must load, so the front end keeps advancing.
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (ex_muldiv_start && MD_MULTI) begin
        ex_hold    = 1'b1;
        state_next = ST_MULDIV;
        cnt_next   = MD_CNT_INIT;
      end else if (load_use) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end else if (is_muldiv) begin
      // Branch and mul/div start inputs are meaningless while EX is occupied.
      ctrl_state  = 2'd2;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (cnt_reg != 4'd0) begin
        ex_hold    = 1'b1;
        state_next = ST_MULDIV;
        cnt_next   = cnt_reg - 4'd1;
      end else if (load_use) begin
        // Release cycle: EX frees up, but a pending load-use still stalls.
        idex_bubble = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_reg <= ST_INIT;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      stall_cnt_reg <= '0;
    end else if ((ctrl_state != 2'd0) && !pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_count = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 32;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_memread, ex_branch_taken, ex_muldiv_start;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_count;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset_in        (reset_in),
    .ifid_rs         (ifid_rs),
    .ifid_rt         (ifid_rt),
    .ifid_uses_rt    (ifid_uses_rt),
    .idex_memread    (idex_memread),
    .idex_rt         (idex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_muldiv_start (ex_muldiv_start),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .ex_hold         (ex_hold),
    .ctrl_state      (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: "in_init" marks the one frozen cycle after reset;
  // busy_left is how many more EX cycles the current mul/div still needs
  // (the last of them is the release cycle).
  bit     in_init;
  int     busy_left;
  longint stall_model;

  function automatic bit model_load_use();
    return idex_memread && idex_rt != 0 &&
           (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
  endfunction

  // Packed as {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, ctrl_state}
  function automatic logic [6:0] model_out();
    bit lu;
    lu = model_load_use();
    if (in_init)        return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    if (busy_left > 1)  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    if (busy_left == 1) return {!lu, !lu, 1'b0, lu, 1'b0, 2'd2};
    if (ex_branch_taken) return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
    if (ex_muldiv_start && LAT > 1) return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    if (lu)             return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
  endfunction

  function automatic logic [6:0] dut_out();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, ctrl_state};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_init     = 1'b1;
    busy_left   = 0;
    stall_model = 0;
  endtask

  // Advance the model across one rising edge with the current inputs.
  task automatic model_step();
    logic [6:0] e;
    e = model_out();
    if (!in_init && !e[6]) begin
      if (stall_model < ((64'd1 << CW) - 1)) stall_model++;
    end
    if (in_init)                                   in_init = 1'b0;
    else if (busy_left > 0)                        busy_left--;
    else if (!ex_branch_taken && ex_muldiv_start && LAT > 1) busy_left = LAT - 1;
  endtask

  task automatic check_all(input string tag);
    check(tag, {25'd0, dut_out()}, {25'd0, model_out()});
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_cnt"}, stall_count, stall_model[31:0]);
`endif
  endtask

  // One clock cycle: drive after the falling edge, check mid-low-phase,
  // then let the rising edge update both DUT and model.
  task automatic cyc(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mr, input logic [4:0] irt,
                     input logic br, input logic ms);
    @(negedge clk);
    ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
    idex_memread = mr; idex_rt = irt;
    ex_branch_taken = br; ex_muldiv_start = ms;
    #1;
    check_all(tag);
    $display("cycle %-10s rs=%0d rt=%0d urt=%0d mr=%0d irt=%0d br=%0d ms=%0d -> out=%b",
             tag, rs, rt, urt, mr, irt, br, ms, dut_out());
    @(posedge clk);
    model_step();
  endtask

  initial begin
    reset_in = 1'b0;
    ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
    idex_memread = 0; idex_rt = 0; ex_branch_taken = 0; ex_muldiv_start = 0;
    model_reset();

    // 1. Reset held for 3 cycles, then one INIT cycle, then RUN.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_all("in_reset");
    end
    @(posedge clk); #2 reset_in = 1'b1;
    cyc("init_cyc", 0, 0, 0, 0, 0, 0, 0);
    cyc("run_idle", 0, 0, 0, 0, 0, 0, 0);

    // 2. Load-use detection corner cases.
    cyc("lu_rs",    5, 0, 0, 1, 5, 0, 0);
    cyc("lu_rt0",   0, 0, 1, 1, 0, 0, 0);
    cyc("lu_rt_nu", 1, 5, 0, 1, 5, 0, 0);
    cyc("lu_rt_u",  1, 5, 1, 1, 5, 0, 0);
    cyc("no_load",  5, 5, 1, 0, 5, 0, 0);

    // 3. Mul/div pulse: hold cycles 0..2, release cycle 3, RUN in cycle 4.
    cyc("md_c0", 0, 0, 0, 0, 0, 0, 1);
    cyc("md_c1", 0, 0, 0, 0, 0, 1, 1);
    cyc("md_c2", 3, 0, 0, 1, 3, 0, 0);
    cyc("md_c3", 0, 0, 0, 0, 0, 0, 0);
    cyc("md_c4", 0, 0, 0, 0, 0, 0, 0);

    // Release cycle with a pending load-use.
    cyc("mdl_c0", 0, 0, 0, 0, 0, 0, 1);
    cyc("mdl_c1", 0, 0, 0, 0, 0, 0, 0);
    cyc("mdl_c2", 0, 0, 0, 0, 0, 0, 0);
    cyc("mdl_c3", 7, 0, 0, 1, 7, 0, 0);
    cyc("mdl_c4", 0, 0, 0, 0, 0, 0, 0);

    // 4. Branch beats mul/div start and load-use; state stays RUN.
    cyc("br_prio",  5, 0, 0, 1, 5, 1, 1);
    cyc("br_after", 0, 0, 0, 0, 0, 0, 0);

    // 5. Asynchronous reset in the middle of MULDIV cycle 1.
    cyc("ar_c0", 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    ex_muldiv_start = 0;
    #1;
    check_all("ar_c1");
    #1 reset_in = 1'b0;
    model_reset();
    #1;
    check_all("ar_async");
    @(posedge clk); #2 reset_in = 1'b1;
    cyc("ar_init", 0, 0, 0, 0, 0, 0, 0);
    cyc("ar_run",  0, 0, 0, 0, 0, 0, 0);
    cyc("ar_run2", 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with small register numbers to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard/sequencing controller for the 5-stage 32-bit MIPS pipeline. It decides each cycle whether PC and IF/ID advance, whether IF/ID is flushed, and whether the ID/EX register loads a bubble (control fields zeroed) or holds. It covers load-use stalls, taken-branch flushes resolved in EX, and multi-cycle mul/div occupancy of EX. Sits beside the IF/ID, ID/EX and EX/MEM registers and drives their write-enable and flush inputs.

Parameters:
MULDIV_LAT, 4, total EX-stage cycles of a mul/div op; legal range 1..16
CNT_W, 32, width of stall counter (optional feature only)

Ports:
clk  in  1  pipeline clock, rising edge
reset_in  in  1  asynchronous, active-low reset
ifid_rs  in  5  rs field of instruction in IF/ID
ifid_rt  in  5  rt field of instruction in IF/ID
ifid_uses_rt  in  1  IF/ID instruction reads rt as a source
idex_memread  in  1  instruction in ID/EX is a load
idex_rt  in  5  destination rt of instruction in ID/EX
ex_branch_taken  in  1  branch in EX resolved taken this cycle
ex_muldiv_start  in  1  first EX cycle of a mul/div op
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP
idex_bubble  out  1  ID/EX loads zero WB/M/EX control fields
ex_hold  out  1  ID/EX and EX hold; EX/MEM loads bubble
ctrl_state  out  2  current state encoding (debug)

Behaviour:
- States: INIT=0, RUN=1, MULDIV=2; 3 unused, decodes as INIT. 4-bit down-counter cnt.
- reset_in low (async): state=INIT, cnt=0. Outputs in INIT: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, ex_hold=0, ctrl_state=0.
- INIT -> RUN unconditionally on first rising edge with reset_in high (exactly one INIT cycle after release).
- Outputs are combinational from state, cnt and inputs (zero-latency decode); only state/cnt are registered.
- load_use = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt)).
- RUN, priority high to low:
  - ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; ex_muldiv_start and load_use ignored this cycle.
  - ex_muldiv_start with MULDIV_LAT>1: pc_write=0, ifid_write=0, ex_hold=1; next state MULDIV, cnt<=MULDIV_LAT-2.
  - ex_muldiv_start with MULDIV_LAT=1: no effect; stay RUN.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1, single cycle; stay RUN.
  - none: pc_write=1, ifid_write=1, others 0.
- MULDIV: cnt!=0: pc_write=0, ifid_write=0, ex_hold=1, cnt decrements. cnt==0: release (pc_write=1, ifid_write=1, ex_hold=0); load_use is evaluated as in RUN; next state RUN.
- In MULDIV, ex_branch_taken and ex_muldiv_start are ignored (EX occupied).
- ex_hold is asserted for exactly MULDIV_LAT-1 consecutive cycles, starting in the start cycle.
- idex_bubble and ex_hold are never both 1. ifid_flush implies idex_bubble.
- Reset asserted mid-MULDIV: immediate INIT, cnt cleared, pipeline flushed. An in-flight mul/div is abandoned.

Optional Feature:
HAZARD_PERF_CNT_EN defined:
- Adds output stall_count [CNT_W-1:0].
- Increments on every cycle with state!=INIT and pc_write=0.
- Saturates at all-ones. Cleared to 0 by reset_in.

HAZARD_PERF_CNT_EN undefined:
- Port and counter are absent.
- All other behaviour is identical.

Test Plan:
1. reset_in low 3 cycles, then high -> during reset and first cycle after: pc_write=0, ifid_flush=1, idex_bubble=1, ctrl_state=0; next cycle ctrl_state=1, pc_write=1.
2. RUN, idex_memread=1, idex_rt=5, ifid_rs=5 -> same cycle pc_write=0, ifid_write=0, idex_bubble=1; repeat with idex_rt=0 -> no stall; with ifid_rt=5, ifid_uses_rt=0 -> no stall.
3. MULDIV_LAT=4, one-cycle ex_muldiv_start pulse -> ex_hold=1 in cycles 0,1,2; cycle 3 ex_hold=0, pc_write=1; ctrl_state=2 in cycles 1..3; cycle 4 ctrl_state=1.
4. ex_branch_taken=1 together with load_use true and ex_muldiv_start=1 -> pc_write=1, ifid_flush=1, idex_bubble=1, ex_hold=0; state stays RUN.
5. reset_in driven low mid-edge in MULDIV cycle 1 -> outputs switch to INIT values before the next clock edge; after release, one INIT cycle, then RUN with cnt=0.
6. HAZARD_PERF_CNT_EN defined, MULDIV_LAT=4: one load_use stall plus one mul/div op -> stall_count=4; CNT_W=2 with 5 stalls -> stall_count=3 (saturated).
